// File: rtl/data_store_controller_pkg.sv
// Shared definitions for the data store controller: store widths, FSM states
// and the default write-acknowledge timeout.
package data_store_controller_pkg;

    // func3 encodings of the supported store widths
    localparam logic [2:0] Func3Sb = 3'b000;
    localparam logic [2:0] Func3Sh = 3'b001;
    localparam logic [2:0] Func3Sw = 3'b010;

    // Longest wait for mem_ack before the store is abandoned
    localparam int unsigned DefaultTimeoutCycles = 255;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2,
        StFault = 2'd3
    } state_e;

endpackage

// File: rtl/data_store_controller_if.sv
// Pipeline and data-memory signals of the store controller, bundled as one bus.
// slave: the controller itself; master: pipeline plus memory environment.
interface data_store_controller_if;

    // Pipeline side
    logic        store_en;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] rs2_data;
    logic        busywait;
    logic        store_done;
    logic        store_fault;

    // Memory side
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_ack;

    modport master (
        output store_en, func3, addr, rs2_data, mem_ack,
        input  busywait, store_done, store_fault,
        input  mem_write, mem_addr, mem_wdata, mem_byte_en
    );

    modport slave (
        input  store_en, func3, addr, rs2_data, mem_ack,
        output busywait, store_done, store_fault,
        output mem_write, mem_addr, mem_wdata, mem_byte_en
    );

endinterface

// File: rtl/store_lane_align.sv
// Combinational store formatter: turns width, low address bits and
// right-justified data into byte-lane enables and lane-replicated write data,
// and flags illegal widths and misaligned addresses.
module store_lane_align
    import data_store_controller_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2_data,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic        fault
);

    // Decode width into lane enables, replicated data and the fault flag
    always_comb begin
        byte_en = 4'b0000;
        wdata   = 32'h0;
        fault   = 1'b0;
        case (func3)
            Func3Sb: begin
                byte_en = 4'b0001 << addr_lo;
                wdata   = {4{rs2_data[7:0]}};
            end
            Func3Sh: begin
                fault   = addr_lo[0];
                byte_en = 4'b0011 << {addr_lo[1], 1'b0};
                wdata   = {2{rs2_data[15:0]}};
            end
            Func3Sw: begin
                fault   = (addr_lo != 2'b00);
                byte_en = 4'b1111;
                wdata   = rs2_data;
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_store_controller.sv
// Store controller: accepts one store from the pipeline, formats it into a
// word write with byte enables, holds the write until memory acknowledges,
// and reports completion or fault (misalignment, illegal width, timeout).
module data_store_controller
    import data_store_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input logic                   clk,
    input logic                   reset,
    data_store_controller_if.slave bus
);

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  byte_en_q, byte_en_d;

    logic [3:0]  align_byte_en;
    logic [31:0] align_wdata;
    logic        align_fault;

    store_lane_align u_align (
        .func3    (bus.func3),
        .addr_lo  (bus.addr[1:0]),
        .rs2_data (bus.rs2_data),
        .byte_en  (align_byte_en),
        .wdata    (align_wdata),
        .fault    (align_fault)
    );

    // State, timeout counter and latched write request, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= 8'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            byte_en_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            byte_en_q <= byte_en_d;
        end
    end

    // Next-state: accept a store, wait for ack or timeout, then pulse result
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        byte_en_d = byte_en_q;
        unique case (state_q)
            StIdle: begin
                if (bus.store_en) begin
                    if (align_fault) begin
                        state_d = StFault;
                    end else begin
                        state_d   = StWrite;
                        count_d   = 8'd0;
                        addr_d    = {bus.addr[31:2], 2'b00};
                        wdata_d   = align_wdata;
                        byte_en_d = align_byte_en;
                    end
                end
            end
            StWrite: begin
                // An ack arriving on the limit cycle still completes the store
                if (bus.mem_ack) begin
                    state_d = StDone;
                end else begin
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                    if (count_d >= TimeoutLimit) begin
                        state_d = StFault;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StFault: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: memory request only while writing; stall starts in request cycle
    always_comb begin
        bus.mem_write   = (state_q == StWrite);
        bus.mem_byte_en = (state_q == StWrite) ? byte_en_q : 4'b0000;
        bus.mem_addr    = addr_q;
        bus.mem_wdata   = wdata_q;
        bus.store_done  = (state_q == StDone);
        bus.store_fault = (state_q == StFault);
        bus.busywait    = ((state_q == StIdle) && bus.store_en) || (state_q == StWrite);
    end

endmodule

// File: tb/tb_data_store_controller.sv
// Bench for data_store_controller: directed stores against a transaction-level
// model checked every cycle, plus hand-computed expectations.
module tb_data_store_controller;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_store_controller_if bus ();

    data_store_controller #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic        flt;
        logic [3:0]  be;
        logic [31:0] wd;
    } align_t;

    // Store of 2^func3 bytes at byte offset off: lanes off..off+size-1,
    // lane i carries data byte (i mod size).
    function automatic align_t model_align(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
        align_t r;
        int size;
        int off;
        r = '0;
        if (f3 > 3'd2) begin
            r.flt = 1'b1;
            return r;
        end
        size = 1 << f3;
        off  = int'(a[1:0]);
        if ((off % size) != 0) begin
            r.flt = 1'b1;
            return r;
        end
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + size) r.be[i] = 1'b1;
            r.wd[8*i +: 8] = d[8*(i % size) +: 8];
        end
        return r;
    endfunction

    align_t      al;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_fault = 1'b0;
    int          m_waited = 0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wd = 32'h0;
    logic [3:0]  m_be = 4'b0;

    always_comb al = model_align(bus.func3, bus.addr, bus.rs2_data);

    // Transaction model advanced on each clock
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_fault <= 1'b0; m_waited <= 0;
            m_addr <= 32'h0; m_wd <= 32'h0; m_be <= 4'b0;
        end else if (m_done || m_fault) begin
            m_done  <= 1'b0;
            m_fault <= 1'b0;
        end else if (m_busy) begin
            if (bus.mem_ack) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else if (m_waited + 1 >= TO) begin
                m_busy  <= 1'b0;
                m_fault <= 1'b1;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else if (bus.store_en) begin
            if (al.flt) begin
                m_fault <= 1'b1;
            end else begin
                m_busy   <= 1'b1;
                m_waited <= 0;
                m_addr   <= {bus.addr[31:2], 2'b00};
                m_wd     <= al.wd;
                m_be     <= al.be;
            end
        end
    end

    // Compare DUT against the model every cycle, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_mem_write", bus.mem_write, m_busy);
            check("cmp_mem_byte_en", bus.mem_byte_en, m_busy ? m_be : 4'b0);
            check("cmp_mem_addr", bus.mem_addr, m_addr);
            check("cmp_mem_wdata", bus.mem_wdata, m_wd);
            check("cmp_store_done", bus.store_done, m_done);
            check("cmp_store_fault", bus.store_fault, m_fault);
            check("cmp_busywait", bus.busywait,
                  m_busy || (!m_done && !m_fault && bus.store_en));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bus.store_en = 1'b1;
        bus.func3    = f3;
        bus.addr     = a;
        bus.rs2_data = d;
    endtask

    task automatic idle();
        bus.store_en = 1'b0;
    endtask

    initial begin
        int bw;
        int n;
        reset        = 1'b1;
        bus.store_en = 1'b0;
        bus.func3    = 3'b000;
        bus.addr     = 32'h0;
        bus.rs2_data = 32'h0;
        bus.mem_ack  = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_byte_en", bus.mem_byte_en, 4'b0000);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_done_fault", {bus.store_done, bus.store_fault}, 2'b00);
        reset = 1'b0;
        step();

        // SB at 0x103, ack on 2nd write cycle, done in 4th cycle
        req(3'b000, 32'h0000_0103, 32'hAABB_CCDD);
        #1 check("sb_busy_req", bus.busywait, 1'b1);
        step();
        idle();
        check("sb_byte_en", bus.mem_byte_en, 4'b1000);
        check("sb_wdata", bus.mem_wdata, 32'hDDDD_DDDD);
        check("sb_mem_addr", bus.mem_addr, 32'h0000_0100);
        check("sb_mem_write", bus.mem_write, 1'b1);
        step();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("sb_done_cycle4", bus.store_done, 1'b1);
        step();
        check("sb_done_once", bus.store_done, 1'b0);

        // SH at 0x202, ack after one cycle, stall exactly two cycles
        bw = 0;
        req(3'b001, 32'h0000_0202, 32'h1234_ABCD);
        #1 bw += int'(bus.busywait);
        step();
        idle();
        bus.mem_ack = 1'b1;
        #1 bw += int'(bus.busywait);
        check("sh_byte_en", bus.mem_byte_en, 4'b1100);
        check("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
        step();
        bus.mem_ack = 1'b0;
        #1 bw += int'(bus.busywait);
        check("sh_done", bus.store_done, 1'b1);
        check("sh_busy_cycles", bw, 2);
        step();

        // Misaligned SW: fault pulse, no memory access
        req(3'b010, 32'h0000_0306, 32'h0BAD_0BAD);
        step();
        idle();
        check("sw_mis_fault", bus.store_fault, 1'b1);
        check("sw_mis_no_write", bus.mem_write, 1'b0);
        check("sw_mis_busy", bus.busywait, 1'b0);
        step();
        check("sw_mis_fault_once", bus.store_fault, 1'b0);

        // Illegal func3, with a store held during the fault cycle (ignored)
        req(3'b011, 32'h0000_0100, 32'h1111_1111);
        step();
        req(3'b010, 32'h0000_0500, 32'h5555_5555);
        #1 check("f3_fault", bus.store_fault, 1'b1);
        check("f3_busy_in_fault", bus.busywait, 1'b0);
        step();
        idle();
        #1 check("f3_store_ignored", bus.mem_write, 1'b0);

        // Misaligned SH
        req(3'b001, 32'h0000_0201, 32'h0000_7777);
        step();
        idle();
        check("sh_mis_fault", bus.store_fault, 1'b1);
        step();

        // Stray ack while idle
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("idle_ack_no_done", {bus.store_done, bus.mem_write}, 2'b00);
        step();

        // SW with no ack: TO write cycles then fault
        req(3'b010, 32'h0000_0040, 32'hCAFE_F00D);
        step();
        idle();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.mem_write) break;
            n++;
            step();
        end
        check("to_write_cycles", n, TO);
        check("to_fault", bus.store_fault, 1'b1);
        step();
        check("to_back_idle", {bus.store_fault, bus.busywait, bus.mem_write}, 3'b000);

        // Ack on the limit cycle wins over timeout
        req(3'b010, 32'h0000_0044, 32'h0102_0304);
        step();
        idle();
        step();
        step();
        step();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("lim_ack_done", {bus.store_done, bus.store_fault}, 2'b10);
        step();

        // Reset in 2nd write cycle, late ack ignored, then a clean store
        req(3'b010, 32'h0000_0080, 32'hDEAD_BEEF);
        step();
        idle();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        check("rw_no_write", bus.mem_write, 1'b0);
        check("rw_byte_en", bus.mem_byte_en, 4'b0000);
        check("rw_mem_addr", bus.mem_addr, 32'h0);
        check("rw_no_pulse", {bus.store_done, bus.store_fault}, 2'b00);
        step();
        bus.mem_ack = 1'b0;
        check("rw_late_ack", {bus.store_done, bus.store_fault}, 2'b00);
        req(3'b010, 32'h0000_0084, 32'h1122_3344);
        step();
        idle();
        bus.mem_ack = 1'b1;
        check("b2b_mem_addr", bus.mem_addr, 32'h0000_0084);
        check("b2b_wdata", bus.mem_wdata, 32'h1122_3344);
        check("b2b_byte_en", bus.mem_byte_en, 4'b1111);
        step();
        bus.mem_ack = 1'b0;
        check("b2b_done", bus.store_done, 1'b1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
